// File: rtl/ex_pkg.sv
// Shared constants for the EX stage: widths, ALU opcodes, mul/div FSM states and op codes.
package ex_pkg;

   localparam int unsigned DEF_NB_DATA   = 32;
   localparam int unsigned DEF_NB_REG    = 5;
   localparam int unsigned DEF_NB_OP     = 5;
   localparam int unsigned DEF_MD_CYCLES = DEF_NB_DATA;

   localparam logic [DEF_NB_OP-1:0] OP_ADD   = 5'd0;
   localparam logic [DEF_NB_OP-1:0] OP_SUB   = 5'd1;
   localparam logic [DEF_NB_OP-1:0] OP_AND   = 5'd2;
   localparam logic [DEF_NB_OP-1:0] OP_OR    = 5'd3;
   localparam logic [DEF_NB_OP-1:0] OP_XOR   = 5'd4;
   localparam logic [DEF_NB_OP-1:0] OP_NOR   = 5'd5;
   localparam logic [DEF_NB_OP-1:0] OP_SLT   = 5'd6;
   localparam logic [DEF_NB_OP-1:0] OP_SLTU  = 5'd7;
   localparam logic [DEF_NB_OP-1:0] OP_SLL   = 5'd8;
   localparam logic [DEF_NB_OP-1:0] OP_SRL   = 5'd9;
   localparam logic [DEF_NB_OP-1:0] OP_SRA   = 5'd10;
   localparam logic [DEF_NB_OP-1:0] OP_LUI   = 5'd11;
   localparam logic [DEF_NB_OP-1:0] OP_MFHI  = 5'd12;
   localparam logic [DEF_NB_OP-1:0] OP_MFLO  = 5'd13;
   localparam logic [DEF_NB_OP-1:0] OP_MULT  = 5'd14;
   localparam logic [DEF_NB_OP-1:0] OP_MULTU = 5'd15;
   localparam logic [DEF_NB_OP-1:0] OP_DIV   = 5'd16;
   localparam logic [DEF_NB_OP-1:0] OP_DIVU  = 5'd17;

   // Mul/div FSM encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Mul/div unit op: {is_div, is_unsigned}
   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

endpackage

// File: rtl/execute_stage_muldiv.sv
// Iterative multiply/divide unit with HI/LO. Divider present only when EX_DIVIDER_EN is defined.
module muldiv_unit
   import ex_pkg::*;
#(
   parameter int unsigned NB_DATA   = DEF_NB_DATA,
   parameter int unsigned MD_CYCLES = DEF_MD_CYCLES
) (
   input  logic               clk,
   input  logic               rst_i,
   input  logic               halt_i,
   input  logic               start_i,
   input  logic [1:0]         op_i,
   input  logic [NB_DATA-1:0] a_i,
   input  logic [NB_DATA-1:0] b_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [NB_DATA-1:0] hi_o,
   output logic [NB_DATA-1:0] lo_o
);

   localparam int unsigned NB_CNT = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
   localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(MD_CYCLES - 1);

   logic [1:0]           state_q, state_d;
   logic [NB_CNT-1:0]    cnt_q, cnt_d;
   logic [NB_DATA-1:0]   acc_q, acc_d, work_q, work_d, b_q, b_d;
   logic [NB_DATA-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic                 neg_res_q, neg_res_d;
   logic                 start_ok, a_neg, b_neg;
   logic [NB_DATA-1:0]   a_mag, b_mag;
   logic [NB_DATA:0]     mul_sum;
   logic [NB_DATA-1:0]   acc_n, work_n, res_hi, res_lo;
   logic [2*NB_DATA-1:0] prod, prod_fix;
`ifdef EX_DIVIDER_EN
   logic                 is_div_q, is_div_d, neg_rem_q, neg_rem_d, dz_q, dz_d;
   logic [NB_DATA:0]     div_rs, div_trial;

   assign start_ok = start_i;
`else
   assign start_ok = start_i & ~op_i[1];
`endif

   // Signed ops work on magnitudes; signs are restored on the final step
   assign a_neg = ~op_i[0] & a_i[NB_DATA-1];
   assign b_neg = ~op_i[0] & b_i[NB_DATA-1];
   assign a_mag = a_neg ? NB_DATA'(-a_i) : a_i;
   assign b_mag = b_neg ? NB_DATA'(-b_i) : b_i;

   // One shift-add (or restoring-subtract) iteration plus sign-fixed results of that iteration
   always_comb begin
      mul_sum  = {1'b0, acc_q} + (work_q[0] ? {1'b0, b_q} : (NB_DATA+1)'(0));
      acc_n    = mul_sum[NB_DATA:1];
      work_n   = {mul_sum[0], work_q[NB_DATA-1:1]};
      prod     = {acc_n, work_n};
      prod_fix = neg_res_q ? (2*NB_DATA)'(-prod) : prod;
      res_hi   = prod_fix[2*NB_DATA-1:NB_DATA];
      res_lo   = prod_fix[NB_DATA-1:0];
`ifdef EX_DIVIDER_EN
      div_rs    = {acc_q, work_q[NB_DATA-1]};
      div_trial = div_rs - {1'b0, b_q};
      if (is_div_q) begin
         if (!div_trial[NB_DATA]) begin
            acc_n  = div_trial[NB_DATA-1:0];
            work_n = {work_q[NB_DATA-2:0], 1'b1};
         end else begin
            acc_n  = div_rs[NB_DATA-1:0];
            work_n = {work_q[NB_DATA-2:0], 1'b0};
         end
         res_lo = dz_q ? '1 : (neg_res_q ? NB_DATA'(-work_n) : work_n);
         res_hi = neg_rem_q ? NB_DATA'(-acc_n) : acc_n;
      end
`endif
   end

   // FSM next state: IDLE -> BUSY (MD_CYCLES steps) -> DONE -> IDLE
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      work_d    = work_q;
      b_d       = b_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      neg_res_d = neg_res_q;
`ifdef EX_DIVIDER_EN
      is_div_d  = is_div_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               state_d   = ST_BUSY;
               cnt_d     = '0;
               acc_d     = '0;
               work_d    = a_mag;
               b_d       = b_mag;
               neg_res_d = a_neg ^ b_neg;
`ifdef EX_DIVIDER_EN
               is_div_d  = op_i[1];
               neg_rem_d = a_neg;
               dz_d      = (b_i == '0);
`endif
            end
         end
         ST_BUSY: begin
            acc_d  = acc_n;
            work_d = work_n;
            cnt_d  = NB_CNT'(cnt_q + 1'b1);
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
               hi_d    = res_hi;
               lo_d    = res_lo;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; halt freezes everything
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         work_q    <= '0;
         b_q       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         neg_res_q <= 1'b0;
`ifdef EX_DIVIDER_EN
         is_div_q  <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
`endif
      end else if (!halt_i) begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         work_q    <= work_d;
         b_q       <= b_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         neg_res_q <= neg_res_d;
`ifdef EX_DIVIDER_EN
         is_div_q  <= is_div_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
`endif
      end
   end

   assign busy_o = (state_q == ST_BUSY);
   assign done_o = (state_q == ST_DONE);
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: ALU, operand mux, mul/div stall control and the EX/MEM register.
// Optional iterative divider: define EX_DIVIDER_EN.
module execute_stage
   import ex_pkg::*;
#(
   parameter int unsigned NB_DATA   = DEF_NB_DATA,
   parameter int unsigned NB_REG    = DEF_NB_REG,
   parameter int unsigned NB_OP     = DEF_NB_OP,
   parameter int unsigned MD_CYCLES = DEF_MD_CYCLES
) (
   input  logic               clk,
   input  logic               i_reset,
   input  logic               i_halt,
   input  logic               i_valid,
   input  logic [NB_OP-1:0]   i_alu_op,
   input  logic [NB_DATA-1:0] i_data_a,
   input  logic [NB_DATA-1:0] i_data_b,
   input  logic [NB_DATA-1:0] i_imm,
   input  logic [4:0]         i_shamt,
   input  logic               i_alu_src,
   input  logic [NB_REG-1:0]  i_reg2write,
   input  logic [1:0]         i_width,
   input  logic               i_sign_flag,
   input  logic               i_mem2reg,
   input  logic               i_memWrite,
   input  logic               i_regWrite,
   output logic               o_stall,
   output logic [NB_DATA-1:0] o_result,
   output logic [NB_DATA-1:0] o_data4Mem,
   output logic [NB_REG-1:0]  o_reg2write,
   output logic [1:0]         o_width,
   output logic               o_sign_flag,
   output logic               o_mem2reg,
   output logic               o_memWrite,
   output logic               o_regWrite,
   output logic [NB_DATA-1:0] o_hi,
   output logic [NB_DATA-1:0] o_lo
);

   logic               is_mul, is_div, is_md_iter, md_start, md_busy, md_done, bubble;
   logic [1:0]         md_op;
   logic [NB_DATA-1:0] op_b, alu_res, md_hi, md_lo;
   logic [NB_DATA-1:0] result_q, result_d, data4mem_q, data4mem_d;
   logic [NB_REG-1:0]  reg_q, reg_d;
   logic [1:0]         width_q, width_d;
   logic               sign_q, sign_d, m2r_q, m2r_d, mw_q, mw_d, rw_q, rw_d;

   assign is_mul = (i_alu_op == OP_MULT) | (i_alu_op == OP_MULTU);
   assign is_div = (i_alu_op == OP_DIV)  | (i_alu_op == OP_DIVU);
`ifdef EX_DIVIDER_EN
   assign is_md_iter = is_mul | is_div;
`else
   assign is_md_iter = is_mul;
`endif
   assign md_op    = {is_div, (i_alu_op == OP_MULTU) | (i_alu_op == OP_DIVU)};
   assign md_start = i_valid & is_md_iter & ~md_busy & ~md_done & ~i_halt;
   // DONE drops the stall so the held instruction retires without re-issuing
   assign o_stall  = ~i_reset & (md_busy | (i_valid & is_md_iter & ~md_done));
   // Mul/div ops never write the register file through EX/MEM
   assign bubble   = ~i_valid | is_mul | is_div | o_stall;
   assign op_b     = i_alu_src ? i_imm : i_data_b;

   muldiv_unit #(
      .NB_DATA   (NB_DATA),
      .MD_CYCLES (MD_CYCLES)
   ) u_muldiv (
      .clk     (clk),
      .rst_i   (i_reset),
      .halt_i  (i_halt),
      .start_i (md_start),
      .op_i    (md_op),
      .a_i     (i_data_a),
      .b_i     (i_data_b),
      .busy_o  (md_busy),
      .done_o  (md_done),
      .hi_o    (md_hi),
      .lo_o    (md_lo)
   );

   // Single-cycle ALU
   always_comb begin
      alu_res = '0;
      case (i_alu_op)
         OP_ADD:  alu_res = i_data_a + op_b;
         OP_SUB:  alu_res = i_data_a - op_b;
         OP_AND:  alu_res = i_data_a & op_b;
         OP_OR:   alu_res = i_data_a | op_b;
         OP_XOR:  alu_res = i_data_a ^ op_b;
         OP_NOR:  alu_res = ~(i_data_a | op_b);
         OP_SLT:  alu_res = NB_DATA'($signed(i_data_a) < $signed(op_b));
         OP_SLTU: alu_res = NB_DATA'(i_data_a < op_b);
         OP_SLL:  alu_res = op_b << i_shamt;
         OP_SRL:  alu_res = op_b >> i_shamt;
         OP_SRA:  alu_res = NB_DATA'($signed(op_b) >>> i_shamt);
         OP_LUI:  alu_res = NB_DATA'({i_imm[15:0], 16'h0000});
         OP_MFHI: alu_res = md_hi;
         OP_MFLO: alu_res = md_lo;
         default: alu_res = '0;
      endcase
   end

   // EX/MEM next value: hold on halt, bubble on stall/invalid/mul-div, else load
   always_comb begin
      result_d   = result_q;
      data4mem_d = data4mem_q;
      reg_d      = reg_q;
      width_d    = width_q;
      sign_d     = sign_q;
      m2r_d      = m2r_q;
      mw_d       = mw_q;
      rw_d       = rw_q;
      if (!i_halt) begin
         data4mem_d = i_data_b;
         if (bubble) begin
            result_d = '0;
            reg_d    = '0;
            width_d  = '0;
            sign_d   = 1'b0;
            m2r_d    = 1'b0;
            mw_d     = 1'b0;
            rw_d     = 1'b0;
         end else begin
            result_d = alu_res;
            reg_d    = i_reg2write;
            width_d  = i_width;
            sign_d   = i_sign_flag;
            m2r_d    = i_mem2reg;
            mw_d     = i_memWrite;
            rw_d     = i_regWrite;
         end
      end
   end

   // EX/MEM pipeline register
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         result_q   <= '0;
         data4mem_q <= '0;
         reg_q      <= '0;
         width_q    <= '0;
         sign_q     <= 1'b0;
         m2r_q      <= 1'b0;
         mw_q       <= 1'b0;
         rw_q       <= 1'b0;
      end else begin
         result_q   <= result_d;
         data4mem_q <= data4mem_d;
         reg_q      <= reg_d;
         width_q    <= width_d;
         sign_q     <= sign_d;
         m2r_q      <= m2r_d;
         mw_q       <= mw_d;
         rw_q       <= rw_d;
      end
   end

   assign o_result    = result_q;
   assign o_data4Mem  = data4mem_q;
   assign o_reg2write = reg_q;
   assign o_width     = width_q;
   assign o_sign_flag = sign_q;
   assign o_mem2reg   = m2r_q;
   assign o_memWrite  = mw_q;
   assign o_regWrite  = rw_q;
   assign o_hi        = md_hi;
   assign o_lo        = md_lo;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage with a behavioural reference model.
module tb_execute_stage;
   import ex_pkg::*;

`ifdef EX_DIVIDER_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif
   localparam int MDC = 32;

   logic        clk = 1'b0;
   logic        i_reset, i_halt, i_valid, i_alu_src, i_sign_flag, i_mem2reg, i_memWrite, i_regWrite;
   logic [4:0]  i_alu_op, i_shamt, i_reg2write;
   logic [31:0] i_data_a, i_data_b, i_imm;
   logic [1:0]  i_width;
   logic        o_stall, o_sign_flag, o_mem2reg, o_memWrite, o_regWrite;
   logic [31:0] o_result, o_data4Mem, o_hi, o_lo;
   logic [4:0]  o_reg2write;
   logic [1:0]  o_width;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   always #5 clk = ~clk;

   execute_stage dut (
      .clk(clk), .i_reset(i_reset), .i_halt(i_halt), .i_valid(i_valid), .i_alu_op(i_alu_op),
      .i_data_a(i_data_a), .i_data_b(i_data_b), .i_imm(i_imm), .i_shamt(i_shamt),
      .i_alu_src(i_alu_src), .i_reg2write(i_reg2write), .i_width(i_width),
      .i_sign_flag(i_sign_flag), .i_mem2reg(i_mem2reg), .i_memWrite(i_memWrite),
      .i_regWrite(i_regWrite), .o_stall(o_stall), .o_result(o_result), .o_data4Mem(o_data4Mem),
      .o_reg2write(o_reg2write), .o_width(o_width), .o_sign_flag(o_sign_flag),
      .o_mem2reg(o_mem2reg), .o_memWrite(o_memWrite), .o_regWrite(o_regWrite),
      .o_hi(o_hi), .o_lo(o_lo)
   );

   function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] imm,
                                             input logic [4:0] sh, input logic src);
      logic [31:0] ob;
      ob = src ? imm : b;
      case (op)
         OP_ADD:  return a + ob;
         OP_SUB:  return a - ob;
         OP_AND:  return a & ob;
         OP_OR:   return a | ob;
         OP_XOR:  return a ^ ob;
         OP_NOR:  return ~(a | ob);
         OP_SLT:  return (int'(a) < int'(ob)) ? 32'd1 : 32'd0;
         OP_SLTU: return (a < ob) ? 32'd1 : 32'd0;
         OP_SLL:  return ob << sh;
         OP_SRL:  return ob >> sh;
         OP_SRA:  return 32'(int'(ob) >>> sh);
         OP_LUI:  return {imm[15:0], 16'h0000};
         OP_MFHI: return m_hi;
         OP_MFLO: return m_lo;
         default: return 32'd0;
      endcase
   endfunction

   task automatic md_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sp;
      logic [63:0] up;
      int sa, sb;
      sa = int'(a);
      sb = int'(b);
      if (op == OP_MULT) begin
         sp = longint'(sa) * longint'(sb);
         {m_hi, m_lo} = 64'(sp);
      end else if (op == OP_MULTU) begin
         up = {32'h0, a} * {32'h0, b};
         {m_hi, m_lo} = up;
      end else if (DIV_EN && (op == OP_DIV || op == OP_DIVU)) begin
         if (b == 32'h0) begin
            m_lo = 32'hFFFF_FFFF;
            m_hi = a;
         end else if (op == OP_DIVU) begin
            m_lo = a / b;
            m_hi = a % b;
         end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            m_lo = 32'h8000_0000;
            m_hi = 32'h0;
         end else begin
            m_lo = 32'(sa / sb);
            m_hi = 32'(sa % sb);
         end
      end
   endtask

   task automatic clear_inputs();
      i_valid = 0; i_alu_op = OP_ADD; i_data_a = 0; i_data_b = 0; i_imm = 0; i_shamt = 0;
      i_alu_src = 0; i_reg2write = 0; i_width = 0; i_sign_flag = 0; i_mem2reg = 0;
      i_memWrite = 0; i_regWrite = 0; i_halt = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      i_reset = 1'b1;
      i_valid = 1'b1; i_alu_op = OP_MULT; i_data_a = 32'd3; i_data_b = 32'd4;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if (o_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", o_stall); end
      n_cmp++;
      if ({o_result, o_data4Mem, o_hi, o_lo} !== 128'h0) begin
         n_err++; $display("FAIL reset_data got res=%h d4m=%h hi=%h lo=%h exp=0", o_result, o_data4Mem, o_hi, o_lo);
      end
      n_cmp++;
      if ({o_reg2write, o_width, o_sign_flag, o_mem2reg, o_memWrite, o_regWrite} !== 11'h0) begin
         n_err++; $display("FAIL reset_ctrl got=%h exp=0", {o_reg2write, o_width, o_sign_flag, o_mem2reg, o_memWrite, o_regWrite});
      end
      @(negedge clk);
      clear_inputs();
      i_reset = 1'b0;
   endtask

   task automatic test_add();
      @(negedge clk);
      i_valid = 1; i_alu_op = OP_ADD; i_data_a = 32'd5; i_imm = 32'hFFFF_FFFD; i_alu_src = 1;
      i_data_b = 32'hCAFE_1234; i_memWrite = 1; i_reg2write = 5'd7; i_width = 2'd2;
      @(posedge clk); #1;
      n_cmp++;
      if (o_result !== 32'd2) begin n_err++; $display("FAIL add_result got=%h exp=2", o_result); end
      n_cmp++;
      if (o_data4Mem !== 32'hCAFE_1234) begin n_err++; $display("FAIL add_data4mem got=%h exp=cafe1234", o_data4Mem); end
      n_cmp++;
      if ({o_memWrite, o_regWrite, o_reg2write, o_width} !== {1'b1, 1'b0, 5'd7, 2'd2}) begin
         n_err++; $display("FAIL add_ctrl got mw=%b rw=%b reg=%0d w=%0d exp mw=1 rw=0 reg=7 w=2", o_memWrite, o_regWrite, o_reg2write, o_width);
      end
      @(negedge clk);
      clear_inputs();
   endtask

   // Issue one mul/div op as upstream would (held while stalled), optionally halting mid-operation
   task automatic run_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int halt_at, input int halt_len);
      int n, guard, exp_n;
      bit iter, bub_ok;
      iter  = (op == OP_MULT) || (op == OP_MULTU) || DIV_EN;
      exp_n = iter ? 1 + MDC + halt_len : 0;
      @(negedge clk);
      i_valid = 1; i_alu_op = op; i_data_a = a; i_data_b = b; i_memWrite = 1; i_regWrite = 1;
      n = 0; guard = 0; bub_ok = 1;
      #1;
      while (o_stall === 1'b1 && guard < 200) begin
         n++; guard++;
         i_halt = (halt_len > 0) && (n >= halt_at) && (n < halt_at + halt_len);
         @(posedge clk); #1;
         if (o_memWrite !== 1'b0 || o_regWrite !== 1'b0) bub_ok = 0;
         @(negedge clk); #1;
      end
      i_halt = 0;
      n_cmp++;
      if (n !== exp_n) begin n_err++; $display("FAIL md_stall_len op=%0d got=%0d exp=%0d", op, n, exp_n); end
      n_cmp++;
      if (bub_ok !== 1'b1) begin n_err++; $display("FAIL md_bubble_during_stall op=%0d got=%b exp=1", op, bub_ok); end
      @(posedge clk); #1;
      n_cmp++;
      if ({o_memWrite, o_regWrite} !== 2'b00) begin
         n_err++; $display("FAIL md_retire op=%0d got mw=%b rw=%b exp 0 0", op, o_memWrite, o_regWrite);
      end
      md_model(op, a, b);
      n_cmp++;
      if (o_hi !== m_hi || o_lo !== m_lo) begin
         n_err++; $display("FAIL md_hilo op=%0d a=%h b=%h got hi=%h lo=%h exp hi=%h lo=%h", op, a, b, o_hi, o_lo, m_hi, m_lo);
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_multu_mfhi();
      run_md(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 0);
      @(negedge clk);
      i_valid = 1; i_alu_op = OP_MFHI; i_regWrite = 1;
      @(posedge clk); #1;
      n_cmp++;
      if (o_result !== 32'd1) begin n_err++; $display("FAIL mfhi got=%h exp=1", o_result); end
      @(negedge clk);
      i_alu_op = OP_MFLO;
      @(posedge clk); #1;
      n_cmp++;
      if (o_result !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mflo got=%h exp=fffffffe", o_result); end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_mult_halt();
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      run_md(OP_MULT, a, b, 0, 0);
      run_md(OP_MULT, 32'h1, 32'h1, 0, 0);
      run_md(OP_MULT, a, b, 10, 5);
      run_md(OP_MULTU, $urandom, $urandom, 20, 3);
   endtask

   task automatic test_div();
      run_md(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
      run_md(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      run_md(OP_DIVU, 32'h0000_1234, 32'h0, 0, 0);
      run_md(OP_DIV, 32'hFFFF_FF00, 32'h0, 0, 0);
      run_md(OP_DIVU, $urandom, $urandom_range(1, 5000), 0, 0);
      run_md(OP_DIV, $urandom, $urandom, 4, 2);
   endtask

   task automatic test_reset_mid();
      int n;
      logic [31:0] a, b;
      run_md(OP_MULTU, 32'hFFFF_0000, 32'h0001_0003, 0, 0);
      @(negedge clk);
      i_valid = 1; i_alu_op = OP_MULT; i_data_a = 32'h1357_9BDF; i_data_b = 32'h2468_ACE0;
      n = 0;
      #1;
      while (n < 10 && o_stall === 1'b1) begin
         n++;
         @(negedge clk); #1;
      end
      i_reset = 1'b1;
      #1;
      n_cmp++;
      if (o_stall !== 1'b0) begin n_err++; $display("FAIL reset_mid_stall got=%b exp=0 (after %0d stall cycles)", o_stall, n); end
      n_cmp++;
      if ({o_result, o_data4Mem, o_hi, o_lo, o_memWrite, o_regWrite} !== 130'h0) begin
         n_err++; $display("FAIL reset_mid_outputs got d4m=%h hi=%h lo=%h exp=0", o_data4Mem, o_hi, o_lo);
      end
      m_hi = '0; m_lo = '0;
      @(negedge clk);
      i_reset = 1'b0;
      a = $urandom; b = $urandom;
      i_valid = 1; i_alu_op = OP_ADD; i_data_a = a; i_data_b = b; i_regWrite = 1;
      #1;
      n_cmp++;
      if (o_stall !== 1'b0) begin n_err++; $display("FAIL reset_mid_add_stall got=%b exp=0", o_stall); end
      @(posedge clk); #1;
      n_cmp++;
      if (o_result !== a + b || o_regWrite !== 1'b1) begin
         n_err++; $display("FAIL reset_mid_add got=%h rw=%b exp=%h rw=1", o_result, o_regWrite, a + b);
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_random_alu();
      logic [31:0] e_res, e_d4m;
      logic [2:0]  e_ctl;
      logic [7:0]  e_fld;
      bit          halt, full;
      full = 0; e_res = 0; e_d4m = 0; e_ctl = 0; e_fld = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         halt = (i > 0) && ($urandom_range(0, 5) == 0);
         i_halt = halt;
         i_valid = ($urandom_range(0, 3) != 0);
         i_alu_op = 5'($urandom_range(0, 13));
         i_data_a = $urandom; i_data_b = $urandom; i_imm = $urandom;
         if ($urandom_range(0, 1) == 1) i_imm = {{16{i_imm[15]}}, i_imm[15:0]};
         i_shamt = 5'($urandom); i_alu_src = 1'($urandom);
         i_reg2write = 5'($urandom); i_width = 2'($urandom); i_sign_flag = 1'($urandom);
         i_mem2reg = 1'($urandom); i_memWrite = 1'($urandom); i_regWrite = 1'($urandom);
         if (!halt) begin
            e_d4m = i_data_b;
            full  = i_valid;
            if (i_valid) begin
               e_res = alu_model(i_alu_op, i_data_a, i_data_b, i_imm, i_shamt, i_alu_src);
               e_ctl = {i_mem2reg, i_memWrite, i_regWrite};
               e_fld = {i_reg2write, i_width, i_sign_flag};
            end else begin
               e_res = 0; e_ctl = 0;
            end
         end
         @(posedge clk); #1;
         n_cmp++;
         if (o_result !== e_res) begin
            n_err++; $display("FAIL rand_result i=%0d op=%0d halt=%b got=%h exp=%h", i, i_alu_op, halt, o_result, e_res);
         end
         n_cmp++;
         if ({o_mem2reg, o_memWrite, o_regWrite} !== e_ctl || o_data4Mem !== e_d4m) begin
            n_err++; $display("FAIL rand_ctrl i=%0d got ctl=%b d4m=%h exp ctl=%b d4m=%h", i, {o_mem2reg, o_memWrite, o_regWrite}, o_data4Mem, e_ctl, e_d4m);
         end
         if (full) begin
            n_cmp++;
            if ({o_reg2write, o_width, o_sign_flag} !== e_fld) begin
               n_err++; $display("FAIL rand_fields i=%0d got=%h exp=%h", i, {o_reg2write, o_width, o_sign_flag}, e_fld);
            end
         end
      end
      @(negedge clk);
      clear_inputs();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_add();
      test_multu_mfhi();
      test_mult_halt();
      test_div();
      test_reset_mid();
      test_random_alu();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Pipeline EX stage of the MIPS core, directly upstream of the data-memory stage.
- Computes the ALU result from forwarded operands, or the effective address for loads and stores.
- Runs MULT/MULTU/DIV/DIVU on an iterative multi-cycle unit with HI/LO registers and stalls upstream while that unit is busy.
- Holds the EX/MEM pipeline register; its outputs drive the memory stage's i_result, i_reg2write, i_width, i_sign_flag, i_mem2reg, i_memWrite, i_regWrite and i_data4Mem.

Parameters:
- NB_DATA, 32, datapath width.
- NB_REG, 5, register-index width.
- NB_OP, 5, ALU opcode width.
- MD_CYCLES, 32, iterations per multiply/divide; must equal NB_DATA.

Ports:
- clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_halt  in  1  freezes all state.
- i_valid  in  1  ID/EX holds a real instruction.
- i_alu_op  in  NB_OP  operation code (package constants).
- i_data_a  in  NB_DATA  rs operand (already forwarded).
- i_data_b  in  NB_DATA  rt operand (already forwarded).
- i_imm  in  NB_DATA  sign-extended immediate.
- i_shamt  in  5  shift amount.
- i_alu_src  in  1  1 = operand B is i_imm.
- i_reg2write  in  NB_REG  destination register.
- i_width  in  2  memory width, passed through.
- i_sign_flag  in  1  passed through.
- i_mem2reg, i_memWrite, i_regWrite  in  1 each  passed through.
- o_stall  out  1  hold IF/ID and ID/EX.
- o_result  out  NB_DATA  registered ALU result or address.
- o_data4Mem  out  NB_DATA  registered i_data_b (store data).
- o_reg2write  out  NB_REG  registered.
- o_width  out  2  registered.
- o_sign_flag, o_mem2reg, o_memWrite, o_regWrite  out  1 each  registered.
- o_hi, o_lo  out  NB_DATA  current HI/LO (debug unit).

Behaviour:
- Reset (async, active-high): all EX/MEM outputs 0; HI/LO 0; FSM to IDLE; counter 0; o_stall 0, dropping immediately even mid-operation.
- Single-cycle ops, latency 1 (EX/MEM captures at the next edge):
  - ADD, SUB: wrap, no overflow trap.
  - AND, OR, XOR, NOR.
  - SLT (signed), SLTU: result 0 or 1.
  - SLL, SRL, SRA: shift by i_shamt.
  - LUI: {imm[15:0], 16'h0}.
  - MFHI, MFLO: read HI/LO.
- Operand B = i_alu_src ? i_imm : i_data_b. o_data4Mem is always i_data_b.
- i_valid=0: EX/MEM loads a bubble; all control outputs 0, o_result 0.
- FSM IDLE -> BUSY -> DONE -> IDLE, for MULT/MULTU/DIV/DIVU:
  - IDLE: a valid mul/div op raises o_stall combinationally. Operands are latched at the edge and the FSM moves to BUSY with counter=0.
  - BUSY: one shift-add or restoring-subtract step per cycle; o_stall=1. When the counter reaches MD_CYCLES-1, HI/LO are written and the FSM moves to DONE.
  - DONE: o_stall=0. The instruction retires into EX/MEM with regWrite=0, memWrite=0. FSM returns to IDLE. DONE never re-issues the op still present at the input.
  - Stall length = 1 + MD_CYCLES cycles.
- While o_stall=1, EX/MEM loads a bubble every cycle, so the memory stage never repeats a store.
- MULT/MULTU: {HI,LO} = 64-bit product.
- DIV/DIVU: LO = quotient, HI = remainder.
- Signed ops use magnitudes internally, then fix signs: quotient negative iff operand signs differ; remainder takes the dividend's sign.
- Divide by zero, still a full MD_CYCLES: LO = 32'hFFFFFFFF, HI = dividend; no trap.
- DIV 0x80000000 / -1: LO = 0x80000000, HI = 0.
- i_halt=1: EX/MEM, FSM, counter and HI/LO all hold; o_stall keeps its value. Halt has priority over issue.

Optional Feature:
- Macro: EX_DIVIDER_EN.
- Defined: DIV/DIVU are iterative, as above.
- Undefined: divider datapath is removed. DIV/DIVU complete in 1 cycle with no stall, leave HI/LO unchanged and retire as a bubble. MULT/MULTU are unaffected.

Decomposition:
- Package ex_pkg: ALU opcode localparams, FSM state encoding (IDLE/BUSY/DONE), MD_CYCLES default, width constants.
- Sub-module muldiv_unit: owns the FSM, counter, multiply/divide datapath, sign fixup and HI/LO. Interface: start, op, a, b -> busy, done, hi, lo.
- execute_stage keeps the ALU, operand mux, stall/bubble logic and EX/MEM register.

Test Plan:
- ADD, a=5, imm=0xFFFFFFFD, alu_src=1, memWrite=1 -> next cycle o_result=2, o_data4Mem=i_data_b, o_memWrite=1.
- MULTU a=0xFFFFFFFF, b=2 -> o_stall high exactly 33 cycles with o_memWrite=0 throughout. Then MFHI -> 1, MFLO -> 0xFFFFFFFE.
- DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=0x1234, b=0 -> LO=0xFFFFFFFF, HI=0x1234 after the full stall.
- Reset asserted in BUSY cycle 10 -> o_stall and all outputs 0 immediately. A following ADD completes in 1 cycle.
- i_halt for 5 cycles during BUSY -> total stall 38 cycles; HI/LO result identical to the unhalted run.
